// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches req starting just above ptr,
// wrapping upward, and returns the first set index.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic                 gnt_valid,
  output logic [$clog2(N)-1:0] gnt_idx
);
  localparam int IDW = $clog2(N);

  logic [N-1:0] w_rot;
  logic [IDW:0] w_start;
  logic [IDW:0] w_off;
  logic [IDW:0] w_sum;

  // Rotate so the highest-priority requester lands at bit 0, priority-encode,
  // then add the start offset back (mod N) to recover the original index.
  always_comb begin
    w_rot     = '0;
    w_off     = '0;
    w_sum     = '0;
    gnt_valid = 1'b0;
    w_start   = (ptr == IDW'(N - 1)) ? '0 : ({1'b0, ptr} + 1'b1);

    for (int i = 0; i < N; i++) begin
      w_sum = w_start + (IDW + 1)'(i);
      if (w_sum >= (IDW + 1)'(N)) w_sum = w_sum - (IDW + 1)'(N);
      w_rot[i] = req[w_sum[IDW-1:0]];
    end

    for (int i = N - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        gnt_valid = 1'b1;
        w_off     = (IDW + 1)'(i);
      end
    end

    w_sum = w_start + w_off;
    if (w_sum >= (IDW + 1)'(N)) w_sum = w_sum - (IDW + 1)'(N);
    gnt_idx = w_sum[IDW-1:0];
  end
endmodule

// File: rtl/rr_mux_sched.sv
// Round-robin scheduler muxing N valid/ready requesters onto one registered
// output. Define RR_MUX_SCHED_LOCK_EN to hold the grant for whole packets (in_last).
module rr_mux_sched #(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         in_valid,
  input  logic [N*W-1:0]       in_data,
  input  logic [N-1:0]         in_last,
  output logic [N-1:0]         in_ready,
  output logic                 out_valid,
  output logic [W-1:0]         out_data,
  output logic [$clog2(N)-1:0] out_id,
  input  logic                 out_ready
);
  localparam int IDW = $clog2(N);

  function automatic logic [W-1:0] word_of(input logic [N*W-1:0] bus,
                                           input logic [IDW-1:0] k);
    return bus[k*W +: W];
  endfunction

  logic           r_out_valid;
  logic [W-1:0]   r_out_data;
  logic [IDW-1:0] r_out_id;
  logic [IDW-1:0] r_ptr;

  logic           w_load;
  logic [N-1:0]   w_req;
  logic           w_gnt_valid;
  logic [IDW-1:0] w_gnt_idx;
  logic           w_xfer;
  logic           w_ptr_upd;

  assign w_load = !r_out_valid || out_ready;
  assign w_xfer = w_load && w_gnt_valid;

`ifdef RR_MUX_SCHED_LOCK_EN
  logic           r_lock;
  logic [IDW-1:0] r_lock_id;
  logic [N-1:0]   w_lock_mask;

  // While a packet is open only its owner may be granted; others are masked.
  assign w_lock_mask = {{(N-1){1'b0}}, 1'b1} << r_lock_id;
  assign w_req       = r_lock ? (in_valid & w_lock_mask) : in_valid;
  assign w_ptr_upd   = in_last[w_gnt_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lock    <= 1'b0;
      r_lock_id <= '0;
    end else if (w_xfer) begin
      r_lock    <= !in_last[w_gnt_idx];
      r_lock_id <= w_gnt_idx;
    end
  end
`else
  logic w_unused_last;

  assign w_unused_last = ^in_last;
  assign w_req         = in_valid;
  assign w_ptr_upd     = 1'b1;
`endif

  rr_arbiter #(.N(N)) u_arb (
    .req       (w_req),
    .ptr       (r_ptr),
    .gnt_valid (w_gnt_valid),
    .gnt_idx   (w_gnt_idx)
  );

  assign in_ready = w_xfer ? ({{(N-1){1'b0}}, 1'b1} << w_gnt_idx) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_id    <= '0;
      r_ptr       <= IDW'(N - 1);
    end else if (w_load) begin
      r_out_valid <= w_gnt_valid;
      if (w_gnt_valid) begin
        r_out_data <= word_of(in_data, w_gnt_idx);
        r_out_id   <= w_gnt_idx;
        if (w_ptr_upd) r_ptr <= w_gnt_idx;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_id    = r_out_id;
endmodule

// File: tb/tb_rr_mux_sched.sv
// Self-checking bench for rr_mux_sched: directed scenarios plus random traffic,
// all compared against a behavioural round-robin model.
module tb_rr_mux_sched;
  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   in_valid = '0;
  logic [N*W-1:0] in_data = '0;
  logic [N-1:0]   in_last = '0;
  logic [N-1:0]   in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [1:0]     out_id;
  logic           out_ready = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  // model state
  int m_valid = 0;
  int m_data  = 0;
  int m_id    = 0;
  int m_ptr   = N - 1;
  int m_lock  = 0;
  int m_lid   = 0;

  int ids[8];
  localparam logic [N*W-1:0] FC_DATA = {8'h33, 8'h22, 8'h11, 8'h00};

  rr_mux_sched #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_id    (out_id),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int exp_grant(input logic [N-1:0] v);
    if (m_lock != 0) return v[m_lid] ? m_lid : -1;
    for (int j = 1; j <= N; j++) begin
      if (v[(m_ptr + j) % N]) return (m_ptr + j) % N;
    end
    return -1;
  endfunction

  task automatic cycle(input logic [N-1:0] v, input logic [N*W-1:0] d,
                       input logic [N-1:0] l, input logic ordy, input logic r);
    int   g;
    logic ld;
    logic lk_en;
`ifdef RR_MUX_SCHED_LOCK_EN
    lk_en = 1'b1;
`else
    lk_en = 1'b0;
`endif
    in_valid  = v;
    in_data   = d;
    in_last   = l;
    out_ready = ordy;
    rst       = r;
    @(negedge clk);
    ld = (m_valid == 0) || ordy;
    g  = exp_grant(v);
    chk("in_ready", 32'(in_ready), (ld && g >= 0) ? (32'd1 << g) : 32'd0);
    @(posedge clk);
    if (r) begin
      m_valid = 0; m_data = 0; m_id = 0; m_ptr = N - 1; m_lock = 0; m_lid = 0;
    end else if (ld) begin
      m_valid = (g >= 0) ? 1 : 0;
      if (g >= 0) begin
        m_data = int'(d[g*W +: W]);
        m_id   = g;
        if (lk_en) begin
          m_lock = l[g] ? 0 : 1;
          m_lid  = g;
          if (l[g]) m_ptr = g;
        end else begin
          m_ptr = g;
        end
      end
    end
    #1;
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("out_id", 32'(out_id), 32'(m_id));
    chk("out_data", 32'(out_data), 32'(m_data));
  endtask

  initial begin
    // reset then idle
    cycle('0, '0, '0, 1'b1, 1'b1);
    cycle('0, '0, '0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) cycle('0, '0, '0, 1'b1, 1'b0);
    chk("idle_valid", 32'(out_valid), 32'd0);

    // full contention: ids 0,1,2,3,0 starting one cycle after first accept
    for (int i = 0; i < 5; i++) begin
      cycle(4'b1111, FC_DATA, 4'b1111, 1'b1, 1'b0);
      ids[i] = int'(out_id);
      chk("fc_data", 32'(out_data), 32'h11 * 32'(i % N));
    end
    for (int i = 0; i < 5; i++) chk("fc_id", 32'(ids[i]), 32'(i % N));

    // backpressure with id 1 held, then next grant must be 2
    cycle('0, '0, '0, 1'b1, 1'b1);
    cycle(4'b1111, FC_DATA, 4'b1111, 1'b1, 1'b0);
    cycle(4'b1111, FC_DATA, 4'b1111, 1'b1, 1'b0);
    chk("bp_held_id", 32'(out_id), 32'd1);
    for (int i = 0; i < 3; i++) begin
      cycle(4'b1111, FC_DATA, 4'b1111, 1'b0, 1'b0);
      chk("bp_stable", 32'(out_id), 32'd1);
    end
    cycle(4'b1111, FC_DATA, 4'b1111, 1'b1, 1'b0);
    chk("bp_next", 32'(out_id), 32'd2);

    // sparse plus wrap
    cycle('0, '0, '0, 1'b1, 1'b1);
    cycle(4'b0100, FC_DATA, 4'b1111, 1'b1, 1'b0);
    chk("sp_g2", 32'(out_id), 32'd2);
    cycle(4'b0011, FC_DATA, 4'b1111, 1'b1, 1'b0);
    chk("sp_g0", 32'(out_id), 32'd0);
    cycle(4'b0011, FC_DATA, 4'b1111, 1'b1, 1'b0);
    chk("sp_g1", 32'(out_id), 32'd1);

    // reset mid-stream
    cycle(4'b1111, FC_DATA, 4'b1111, 1'b0, 1'b0);
    cycle(4'b1111, FC_DATA, 4'b1111, 1'b0, 1'b1);
    chk("rst_mid_valid", 32'(out_valid), 32'd0);
    cycle(4'b1111, FC_DATA, 4'b1111, 1'b1, 1'b0);
    chk("rst_first", 32'(out_id), 32'd0);

    // packet from requester 1 after pointer sits at 0
    cycle('0, '0, '0, 1'b1, 1'b1);
    cycle(4'b0001, FC_DATA, 4'b1111, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cycle(4'b1111, FC_DATA, {2'b11, (i == 2) ? 1'b1 : 1'b0, 1'b1}, 1'b1, 1'b0);
      ids[i] = int'(out_id);
    end
`ifdef RR_MUX_SCHED_LOCK_EN
    chk("pk_w0", 32'(ids[0]), 32'd1);
    chk("pk_w1", 32'(ids[1]), 32'd1);
    chk("pk_w2", 32'(ids[2]), 32'd1);
    chk("pk_w3", 32'(ids[3]), 32'd2);
`else
    chk("pk_w0", 32'(ids[0]), 32'd1);
    chk("pk_w1", 32'(ids[1]), 32'd2);
    chk("pk_w2", 32'(ids[2]), 32'd3);
`endif

    // random traffic
    for (int i = 0; i < 400; i++) begin
      cycle(N'($urandom), {$urandom}, N'($urandom_range(0, 15) | (($urandom_range(0, 1) != 0) ? 4'hF : 4'h0)),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 49) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
